alu_ctrl: RTL and testbench

Sequential command controller that drives the combinational ALU block from the far side of its operand/result interface. It accepts operation commands over a valid/ready handshake and registers the ALU operands, opcode and operand source. It captures the ALU result and zero flag one cycle later, optionally updates an internal accumulator, and returns a response over a second valid/ready handshake. It sits between a command source (sequencer or bus adapter) and the ALU, which is instantiated beside it in the parent.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding used by the ALU select input and the
// controller state encoding.
//   alu_op_e         - 3-bit ALU opcode; encodings above OP_PASS also mean pass A
//   alu_ctrl_state_e - alu_ctrl FSM states
//   is_div_op()      - true for opcodes that need a non-zero divisor
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_MOD  = 3'b100,
        OP_PASS = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } alu_ctrl_state_e;

    function automatic logic is_div_op(logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Command controller for the combinational ALU instantiated beside it.
// Accepts a command over cmd_valid/cmd_ready, registers the ALU operands for one
// EXEC cycle, captures the ALU result, optionally updates the accumulator and
// presents the result over rsp_valid/rsp_ready. DIV/MOD by zero is never issued;
// it is answered directly with an error response.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   cmd_valid/ready          - command handshake
//   cmd_op/a/b               - opcode and operands
//   cmd_use_acc, cmd_acc_wr  - take A from acc / write result to acc
//   alu_sel/a/b              - registered operands to the ALU
//   alu_c, alu_z             - ALU result and zero flag
//   rsp_valid/ready          - response handshake
//   rsp_data/zero/err        - response payload
//   acc                      - accumulator value
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         cmd_use_acc,
    input  logic         cmd_acc_wr,
    output logic [2:0]   alu_sel,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_c,
    input  logic         alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [N-1:0] acc
);

    alu_ctrl_state_e state_q, state_d;

    logic [2:0]   alu_sel_q, alu_sel_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic         acc_wr_q, acc_wr_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_err_q, rsp_err_d;
    logic [N-1:0] acc_q, acc_d;

    logic div_by_zero;

    // Divisor check is on the raw command; the ALU must never see it.
    assign div_by_zero = is_div_op(cmd_op) && (cmd_b == '0);

    always_comb begin
        state_d    = state_q;
        alu_sel_d  = alu_sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        acc_wr_d   = acc_wr_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        acc_d      = acc_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (div_by_zero) begin
                        // Error reply straight away; ALU operands and acc untouched.
                        rsp_data_d = '1;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        alu_sel_d = cmd_op;
                        alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
                        alu_b_d   = cmd_b;
                        acc_wr_d  = cmd_acc_wr;
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                rsp_data_d = alu_c;
                rsp_zero_d = alu_z;
                rsp_err_d  = 1'b0;
                if (acc_wr_q) begin
                    acc_d = alu_c;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_sel_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            acc_wr_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_sel_q  <= alu_sel_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            acc_wr_q   <= acc_wr_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
            acc_q      <= acc_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a behavioural ALU drives alu_c/alu_z, a transaction-level
// model predicts every visible output each cycle, and a negedge compare process
// checks the DUT against it. Directed commands pin the model with literal values.
module tb_alu_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_use_acc;
    logic         cmd_acc_wr;
    logic [2:0]   alu_sel;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_c;
    logic         alu_z;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_zero;
    logic         rsp_err;
    logic [N-1:0] acc;

    alu_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .cmd_acc_wr  (cmd_acc_wr),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .acc         (acc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Arithmetic from plain integer math, result mod 256.
    function automatic logic [7:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = (ia + ib) % 256;
            3'd1:    r = (ia - ib + 256) % 256;
            3'd2:    r = (ia * ib) % 256;
            3'd3:    r = (ib == 0) ? 255 : ia / ib;
            3'd4:    r = (ib == 0) ? 255 : ia % ib;
            default: r = ia;
        endcase
        return r[7:0];
    endfunction

    always_comb begin
        alu_c = alu_fn(alu_sel, alu_a, alu_b);
        alu_z = (alu_c == 8'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: last issued ALU operands, last response, accumulator.
    logic [7:0] m_acc, m_a, m_b, m_data;
    logic [2:0] m_sel;
    logic       m_zero, m_err;

    // Per-cycle expectations read by the compare process.
    logic       chk_en;
    logic       exp_ready, exp_valid, exp_zero, exp_err;
    logic [7:0] exp_data, exp_acc, exp_a, exp_b;
    logic [2:0] exp_sel;

    task automatic model_reset();
        m_acc = 8'd0; m_a = 8'd0; m_b = 8'd0; m_sel = 3'd0;
        m_data = 8'd0; m_zero = 1'b0; m_err = 1'b0;
    endtask

    task automatic set_exp(input logic ready, input logic valid);
        exp_ready = ready;  exp_valid = valid;
        exp_data  = m_data; exp_zero  = m_zero; exp_err = m_err;
        exp_acc   = m_acc;  exp_sel   = m_sel;  exp_a   = m_a; exp_b = m_b;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("rsp_data",  32'(rsp_data),  32'(exp_data));
            chk("rsp_zero",  32'(rsp_zero),  32'(exp_zero));
            chk("rsp_err",   32'(rsp_err),   32'(exp_err));
            chk("acc",       32'(acc),       32'(exp_acc));
            chk("alu_sel",   32'(alu_sel),   32'(exp_sel));
            chk("alu_a",     32'(alu_a),     32'(exp_a));
            chk("alu_b",     32'(alu_b),     32'(exp_b));
            if (!exp_ready && !exp_valid) begin
                chk("no_div0", 32'((alu_sel == 3'd3 || alu_sel == 3'd4) && alu_b == 8'd0), 32'd0);
            end
        end
    end

    // Issue one command starting in an IDLE cycle (#1 after an edge); returns in IDLE.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input logic acc_wr, input int hold,
                          input logic lit_en, input logic [7:0] lit_data,
                          input logic [7:0] lit_acc, input logic rst_exec);
        logic [7:0] ea, res;
        logic       err;
        ea  = use_acc ? m_acc : a;
        err = (op == 3'd3 || op == 3'd4) && (b == 8'd0);
        res = alu_fn(op, ea, b);

        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        cmd_use_acc = use_acc; cmd_acc_wr = acc_wr;
        set_exp(1'b1, 1'b0);
        @(posedge clk); #1;
        // Payload after accept must be ignored.
        cmd_valid = 1'($urandom % 2); cmd_op = 3'($urandom); cmd_a = 8'($urandom);
        cmd_b = 8'($urandom); cmd_use_acc = 1'($urandom); cmd_acc_wr = 1'($urandom);

        if (!err) begin
            m_sel = op; m_a = ea; m_b = b;
            set_exp(1'b0, 1'b0);
            if (rst_exec) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp_data",  32'(rsp_data),  32'd0);
                chk("rst_acc",       32'(acc),       32'd0);
                chk("rst_alu_sel",   32'(alu_sel),   32'd0);
                chk("rst_alu_a",     32'(alu_a),     32'd0);
                model_reset();
                set_exp(1'b1, 1'b0);
                cmd_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                // No stale response may appear after reset release.
                repeat (4) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk); #1;
            m_data = res; m_zero = (res == 8'd0); m_err = 1'b0;
            if (acc_wr) m_acc = res;
        end else begin
            m_data = 8'hFF; m_zero = 1'b0; m_err = 1'b1;
        end
        set_exp(1'b0, 1'b1);
        if (lit_en) begin
            chk("lit_rsp_data", 32'(rsp_data), 32'(lit_data));
            chk("lit_acc",      32'(acc),      32'(lit_acc));
            chk("lit_rsp_err",  32'(rsp_err),  32'(err));
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0; cmd_valid = 1'b1;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1; cmd_valid = 1'($urandom % 2);
        @(posedge clk); #1;
        set_exp(1'b1, 1'b0);
        cmd_valid = 1'b0; rsp_ready = 1'($urandom % 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0;
        cmd_use_acc = 1'b0; cmd_acc_wr = 1'b0; rsp_ready = 1'b0; chk_en = 1'b0;
        model_reset();
        set_exp(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Accumulator chain, divide by zero, backpressure, wrap and zero flag.
        do_cmd(3'd0, 8'd99, 8'd200, 1'b1, 1'b1, 0, 1'b1, 8'd200, 8'd200, 1'b0);
        do_cmd(3'd0, 8'd0,  8'd100, 1'b1, 1'b1, 0, 1'b1, 8'd44,  8'd44,  1'b0);
        do_cmd(3'd3, 8'd9,  8'd0,   1'b0, 1'b1, 2, 1'b1, 8'hFF,  8'd44,  1'b0);
        do_cmd(3'd0, 8'd5,  8'd3,   1'b0, 1'b0, 5, 1'b1, 8'd8,   8'd44,  1'b0);
        do_cmd(3'd2, 8'd20, 8'd13,  1'b0, 1'b0, 1, 1'b1, 8'd4,   8'd44,  1'b0);
        do_cmd(3'd1, 8'd7,  8'd7,   1'b0, 1'b1, 0, 1'b1, 8'd0,   8'd0,   1'b0);
        do_cmd(3'd4, 8'd50, 8'd0,   1'b0, 1'b0, 0, 1'b1, 8'hFF,  8'd0,   1'b0);
        do_cmd(3'd7, 8'd77, 8'd1,   1'b0, 1'b1, 0, 1'b1, 8'd77,  8'd77,  1'b0);

        for (int i = 0; i < 200; i++) begin
            do_cmd(3'($urandom), 8'($urandom),
                   ($urandom % 4 == 0) ? 8'd0 : 8'($urandom),
                   1'($urandom), 1'($urandom), int'($urandom % 4),
                   1'b0, 8'd0, 8'd0, 1'b0);
        end

        // Reset in EXEC with a non-zero accumulator.
        do_cmd(3'd0, 8'd3, 8'd4, 1'b0, 1'b1, 0, 1'b1, 8'd7, 8'd7, 1'b0);
        do_cmd(3'd0, 8'd0, 8'd1, 1'b1, 1'b1, 0, 1'b0, 8'd0, 8'd0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            do_cmd(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom % 3), 1'b0, 8'd0, 8'd0, 1'b0);
        end

        @(posedge clk); #1 chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
